lifo_drain_ctrl: RTL and testbench
==================================

// Module: lifo_drain_ctrl
// PURPOSE
// - Downstream consumer stage for the lifo stack: issues pop requests, captures the registered pop data
//   one cycle later, and presents it as a valid/ready stream with full throughput (1 word/clk).
// - Runs drain sessions gated by drain_en; pulses drain_done when the stack and the internal buffer are both empty.
// PARAMETERS
// - DATA_WIDTH  16  word width; matches the lifo DATA_WIDTH.
// - OUT_DEPTH   2   output buffer entries; minimum 2, needed for full throughput.
// - CNT_W       16  drain_cnt width; used only when LIFO_DRAIN_CNT_EN is defined.
// PORTS
// - clk          in   1           clock; every flop is clocked on the rising edge.
// - rst_n        in   1           reset, asynchronous and active-low.
// - drain_en     in   1           level input; high = run a drain session.
// - lifo_empty   in   1           lifo empty flag.
// - lifo_full    in   1           lifo full flag.
// - lifo_push    in   1           push seen by the lifo this cycle; used for the pop-collision mask.
// - lifo_data    in   DATA_WIDTH  lifo data_out; valid the cycle after an accepted pop.
// - lifo_pop     out  1           pop request to the lifo; combinational.
// - m_valid      out  1           output word valid.
// - m_ready      in   1           downstream ready.
// - m_data       out  DATA_WIDTH  output word; head of the buffer.
// - busy         out  1           registered; high in state ACTIVE.
// - drain_done   out  1           registered; 1-cycle pulse at the end of a session.
// - drain_cnt    out  CNT_W       present only when LIFO_DRAIN_CNT_EN is defined.
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - Outputs: m_valid=0, m_data=0, busy=0, drain_done=0, drain_cnt=0.
//   - Internal: occ=0, inflight=0, state=IDLE.
// - Pop collision mask:
//   - The lifo gives push priority over pop, so a pop is ignored whenever (lifo_push && !lifo_full).
//   - lifo_pop is forced to 0 while that condition holds.
// - Pop issue: lifo_pop = (state==ACTIVE) && drain_en && !lifo_empty && !collision && credit.
//   - credit = (occ+inflight < OUT_DEPTH) || (occ+inflight==OUT_DEPTH && m_valid && m_ready).
// - Capture:
//   - inflight <= lifo_pop at each edge.
//   - When inflight==1, lifo_data is written into the buffer tail at that edge.
//   - Pop-to-m_valid latency is 2 clk when the buffer is empty.
// - Output stream:
//   - m_valid = (occ != 0).
//   - m_data holds stable while m_valid && !m_ready.
//   - Enqueue and dequeue in the same cycle leave occ unchanged.
//   - The buffer never overflows; credit guarantees it.
// - Order: the output words are the stack pop order, i.e. the last word pushed comes out first.
// - FSM (encoding in lifo_pkg):
//   - IDLE: drain_en=1 -> ACTIVE.
//   - ACTIVE:
//     - drain_en=0 -> IDLE. No new pops; the inflight word is still captured and buffered words still drain.
//     - lifo_empty && inflight==0 && occ==0 -> DONE.
//   - DONE: drain_done=1 for this single cycle -> WAIT.
//   - WAIT: drain_en=0 -> IDLE. A new session requires drain_en to fall and rise again.
// - Boundaries:
//   - drain_en=1 with an empty lifo -> ACTIVE -> DONE on the next cycle; no pops issued.
//   - m_ready held 0 -> at most OUT_DEPTH pops are outstanding, then lifo_pop=0 until a dequeue.
//   - A lifo push mid-session is allowed: the new word is popped next and the session continues.
//   - rst_n asserted mid-session -> immediate reset values; the inflight word is lost.
// CONFIGURATION
// - LIFO_DRAIN_CNT_EN defined:
//   - Adds drain_cnt, which counts m_valid && m_ready handshakes.
//   - Cleared on the IDLE->ACTIVE transition; saturates at 2**CNT_W-1; held through DONE, WAIT and IDLE.
// - LIFO_DRAIN_CNT_EN undefined: the drain_cnt port and counter logic do not exist.
// STRUCTURE
// - lifo_pkg: FSM state encoding (IDLE/ACTIVE/DONE/WAIT, 2 bits), plus default DATA_WIDTH and OUT_DEPTH constants.
// - One sub-module, drain_skid_fifo:
//   - OUT_DEPTH-entry synchronous FIFO with an occ output, wr_en/rd_en ports and async active-low reset.
//   - The top level holds the FSM, the credit/collision logic and the optional counter.
// TESTING (bench instantiates lifo DEPTH=16 driving this block)
// - Push 1,2,3,4, drain_en=1, m_ready=1 -> m_data 4,3,2,1 on consecutive cycles; drain_done pulses once; drain_cnt=4.
// - Push 8 words, m_ready=0 for 10 cycles -> exactly 2 pops issued and m_valid=1 with m_data=word8;
//   on release, remaining words follow with no loss or duplication.
// - Hold lifo_push=1 (lifo not full) on the cycle lifo_pop would assert -> lifo_pop=0 that cycle;
//   the pushed word is the next output.
// - Drop drain_en after 2 pops -> the inflight word and buffered words still appear, then state IDLE; no drain_done.
// - Empty lifo, drain_en=1 -> drain_done pulse 1 cycle after busy rises; lifo_pop never asserts; drain_cnt=0.
// - rst_n=0 for 1 cycle mid-stream -> m_valid, busy, drain_done and drain_cnt are 0 immediately;
//   the FSM is IDLE after release.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared definitions for the lifo drain path: drain FSM state encoding and default sizes.
package lifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        WAIT   = 2'd3
    } drain_state_t;

    localparam int unsigned LIFO_DATA_WIDTH = 16;
    localparam int unsigned LIFO_OUT_DEPTH  = 2;

endpackage

// File: rtl/drain_skid_fifo.sv
// Small synchronous FIFO that buffers words popped from the lifo until the downstream accepts them.
module drain_skid_fifo
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LIFO_DATA_WIDTH,
    parameter int unsigned DEPTH      = LIFO_OUT_DEPTH,
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/lifo_drain_ctrl.sv
// Drain controller for the lifo stack: issues pops, buffers the returned words and streams them out.
// Optional handshake counter enabled by defining LIFO_DRAIN_CNT_EN.
module lifo_drain_ctrl
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LIFO_DATA_WIDTH,
    parameter int unsigned OUT_DEPTH  = LIFO_OUT_DEPTH,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic                  lifo_empty,
    input  logic                  lifo_full,
    input  logic                  lifo_push,
    input  logic [DATA_WIDTH-1:0] lifo_data,
    output logic                  lifo_pop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  drain_done
`ifdef LIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_W-1:0]      drain_cnt
`endif
);

    localparam int unsigned     OCC_W   = $clog2(OUT_DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_V = OUT_DEPTH[OCC_W:0];

    drain_state_t     state;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   pending;
    logic             deq;
    logic             collision;
    logic             credit;

    assign deq       = m_valid && m_ready;
    assign collision = lifo_push && !lifo_full;
    assign pending   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    // A full pipeline may still pop when a word leaves this cycle; its slot frees before the data lands.
    assign credit    = (pending < DEPTH_V) || ((pending == DEPTH_V) && deq);
    assign lifo_pop  = (state == ACTIVE) && drain_en && !lifo_empty && !collision && credit;
    assign m_valid   = (occ != '0);

    drain_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (OUT_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (inflight),
        .wr_data(lifo_data),
        .rd_en  (deq),
        .rd_data(m_data),
        .occ    (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            inflight   <= lifo_pop;
            drain_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain_en) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!drain_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (lifo_empty && !inflight && (occ == '0)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!drain_en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LIFO_DRAIN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if ((state == IDLE) && drain_en) begin
            drain_cnt <= '0;
        end else if ((state == ACTIVE) && deq && (drain_cnt != '1)) begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Bench for lifo_drain_ctrl driven by a behavioural 16-entry lifo; checks stream order against a pop scoreboard.
module tb_lifo_drain_ctrl;

    localparam int DW     = 16;
    localparam int OD     = 2;
    localparam int CW     = 16;
    localparam int LDEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          drain_en = 1'b0;
    logic          m_ready = 1'b0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          ovr = 1'b0;
    logic          ovr_empty = 1'b0;
    logic          ovr_full = 1'b0;
    logic          ovr_push = 1'b0;

    logic          lifo_empty, lifo_full, lifo_push, lifo_pop;
    logic          m_valid, busy, drain_done;
    logic [DW-1:0] lifo_data, m_data;
`ifdef LIFO_DRAIN_CNT_EN
    logic [CW-1:0] drain_cnt;
`endif

    logic          mdl_empty = 1'b1;
    logic          mdl_full = 1'b0;
    logic [DW-1:0] mdl_dout = '0;
    logic [DW-1:0] stk[$];

    int checks = 0;
    int errors = 0;

    assign lifo_push  = ovr ? ovr_push  : push_en;
    assign lifo_empty = ovr ? ovr_empty : mdl_empty;
    assign lifo_full  = ovr ? ovr_full  : mdl_full;
    assign lifo_data  = mdl_dout;

    lifo_drain_ctrl #(
        .DATA_WIDTH(DW),
        .OUT_DEPTH (OD),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .drain_en  (drain_en),
        .lifo_empty(lifo_empty),
        .lifo_full (lifo_full),
        .lifo_push (lifo_push),
        .lifo_data (lifo_data),
        .lifo_pop  (lifo_pop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy),
        .drain_done(drain_done)
`ifdef LIFO_DRAIN_CNT_EN
        ,
        .drain_cnt (drain_cnt)
`endif
    );

    // Behavioural lifo: push has priority over pop, data_out registered on pop.
    always @(posedge clk) begin
        if (!ovr) begin
            if (push_en && stk.size() < LDEPTH) stk.push_back(push_data);
            else if (lifo_pop && stk.size() > 0) mdl_dout <= stk.pop_back();
        end
        mdl_empty <= (stk.size() == 0);
        mdl_full  <= (stk.size() == LDEPTH);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard: every accepted pop must appear on the stream exactly once, in pop order.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] out_log[$];
    int            out_cyc[$];
    logic          sb_on = 1'b0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int            cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                out_log.push_back(m_data);
                out_cyc.push_back(cyc);
            end
            if (sb_on) begin
                if (hold_prev) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, hold_data);
                end
                if (m_valid && m_ready) begin
                    check("sb_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("sb_order", m_data, exp_q.pop_front());
                end
                if (lifo_pop) begin
                    check("pop_gate", drain_en && !lifo_empty && !(lifo_push && !lifo_full), 1);
                    check("pop_credit", exp_q.size() < OD, 1);
                    if (stk.size() > 0) exp_q.push_back(stk[$]);
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drain_en = 1'b0;
        m_ready  = 1'b0;
        push_en  = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 1; i <= n; i++) begin
            push_en   = 1'b1;
            push_data = base + DW'(i);
            tick();
        end
        push_en = 1'b0;
        tick();
    endtask

    task automatic run_until_done(input int bound, output bit got);
        got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            tick();
            if (drain_done) got = 1'b1;
        end
    endtask

    typedef struct {
        bit de;
        bit emp;
        bit full;
        bit push;
        bit exp_pop;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit got;
        int fp, fv, pops, dones, busy_k, done_k, n, total;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_drain_done", drain_done, 0);
`ifdef LIFO_DRAIN_CNT_EN
        check("rst_drain_cnt", drain_cnt, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Pop gating table, applied with the controller freshly ACTIVE and an empty buffer
        for (int v = 0; v < 8; v++) begin
            ovr = 1'b1; ovr_empty = 1'b0; ovr_full = 1'b0; ovr_push = 1'b0;
            do_reset();
            drain_en = 1'b1;
            m_ready  = 1'b1;
            tick();
            check("tbl_busy", busy, 1);
            drain_en  = vecs[v].de;
            ovr_empty = vecs[v].emp;
            ovr_full  = vecs[v].full;
            ovr_push  = vecs[v].push;
            #1;
            check($sformatf("tbl_pop_%0d", v), lifo_pop, vecs[v].exp_pop);
        end
        ovr = 1'b0;
        do_reset();
        sb_on = 1'b1;

        // Basic drain: 1,2,3,4 pushed, expect 4,3,2,1 back-to-back
        push_words(4, 16'h0000);
        out_log.delete(); out_cyc.delete();
        drain_en = 1'b1; m_ready = 1'b1;
        fp = -1; fv = -1; dones = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (lifo_pop && fp < 0) fp = k;
            if (m_valid && fv < 0) fv = k;
            if (drain_done) dones++;
        end
        check("basic_latency", fv - fp, 2);
        check("basic_count", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            check($sformatf("basic_word_%0d", i), out_log[i], 4 - i);
            check($sformatf("basic_cycle_%0d", i), out_cyc[i] - out_cyc[0], i);
        end
        check("basic_done_pulses", dones, 1);
`ifdef LIFO_DRAIN_CNT_EN
        check("basic_drain_cnt", drain_cnt, 4);
`endif
        drain_en = 1'b0; tick(); tick();

        // Backpressure: 8 words, m_ready low for 10 cycles
        push_words(8, 16'h0100);
        out_log.delete();
        drain_en = 1'b1; m_ready = 1'b0; pops = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (lifo_pop) pops++;
        end
        check("bp_pops", pops, 2);
        check("bp_valid", m_valid, 1);
        check("bp_head", m_data, 16'h0108);
        m_ready = 1'b1;
        run_until_done(60, got);
        check("bp_done", got, 1);
        check("bp_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            check($sformatf("bp_word_%0d", i), out_log[i], 16'h0108 - 16'(i));
        drain_en = 1'b0; tick(); tick();

        // Push collision on the first pop cycle
        push_words(2, 16'h0020);
        out_log.delete();
        drain_en = 1'b1; m_ready = 1'b1;
        tick();
        push_en = 1'b1; push_data = 16'hABCD;
        #1;
        check("coll_pop_masked", lifo_pop, 0);
        tick();
        push_en = 1'b0;
        run_until_done(40, got);
        check("coll_done", got, 1);
        check("coll_count", out_log.size(), 3);
        if (out_log.size() > 0) check("coll_first", out_log[0], 16'hABCD);
        drain_en = 1'b0; tick(); tick();

        // drain_en dropped after two pops
        push_words(5, 16'h0050);
        out_log.delete();
        drain_en = 1'b1; m_ready = 1'b1; pops = 0;
        for (int k = 0; k < 20 && pops < 2; k++) begin
            tick();
            if (lifo_pop) pops++;
        end
        tick();
        drain_en = 1'b0;
        #1;
        check("drop_no_pop", lifo_pop, 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (drain_done) dones++;
        end
        check("drop_count", out_log.size(), 2);
        if (out_log.size() >= 2) begin
            check("drop_word0", out_log[0], 16'h0055);
            check("drop_word1", out_log[1], 16'h0054);
        end
        check("drop_busy", busy, 0);
        check("drop_no_done", dones, 0);
        check("drop_left", stk.size(), 3);
        drain_en = 1'b1;
        run_until_done(40, got);
        check("drop_rest_done", got, 1);
        drain_en = 1'b0; tick(); tick();

        // Empty lifo session
        drain_en = 1'b1; pops = 0; busy_k = -1; done_k = -1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (lifo_pop) pops++;
            if (busy && busy_k < 0) busy_k = k;
            if (drain_done && done_k < 0) done_k = k;
        end
        check("empty_done_delay", done_k - busy_k, 1);
        check("empty_busy_seen", busy_k >= 0, 1);
        check("empty_no_pop", pops, 0);
`ifdef LIFO_DRAIN_CNT_EN
        check("empty_drain_cnt", drain_cnt, 0);
`endif
        drain_en = 1'b0; tick(); tick();

        // Reset mid-stream
        push_words(6, 16'h0070);
        drain_en = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drain_done", drain_done, 0);
`ifdef LIFO_DRAIN_CNT_EN
        check("mid_rst_drain_cnt", drain_cnt, 0);
`endif
        exp_q.delete();
        drain_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_idle_busy", busy, 0);
        drain_en = 1'b1;
        tick();
        check("mid_rst_restart", busy, 1);
        run_until_done(60, got);
        check("mid_rst_rest_done", got, 1);
        drain_en = 1'b0; tick(); tick();

        // Randomized sessions with random backpressure and occasional mid-session pushes
        for (int s = 0; s < 8; s++) begin
            n = $urandom_range(0, LDEPTH);
            for (int i = 0; i < n; i++) begin
                push_en = 1'b1; push_data = DW'($urandom); tick();
            end
            push_en = 1'b0; tick();
            total = n;
            out_log.delete();
            drain_en = 1'b1; got = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                push_en = (stk.size() > 0) && (stk.size() < LDEPTH) && ($urandom_range(0, 9) == 0);
                push_data = DW'($urandom);
                if (push_en) total++;
                tick();
                if (drain_done) got = 1'b1;
            end
            push_en = 1'b0;
            check("rnd_done", got, 1);
            check("rnd_count", out_log.size(), total);
            check("rnd_sb_empty", exp_q.size(), 0);
            check("rnd_lifo_empty", stk.size(), 0);
`ifdef LIFO_DRAIN_CNT_EN
            check("rnd_drain_cnt", drain_cnt, total);
`endif
            drain_en = 1'b0; m_ready = 1'b1; tick(); tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
